regfile_wb_sched: RTL

Write-port scheduler for the 32×32 register file. It shares the file's single synchronous write port between three writers: the main pipeline writeback, the multiply/divide unit completion, and the CP0 move-from path. After every reset it sequences a zero-fill of registers 1..31 through the normal write port. It sits directly in front of the register file and drives `reg_w`, `RdC`, `Rd_data_in` and `reg_ena`.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_wb_sched_pick.sv | 28 ++
 rtl/regfile_wb_sched.sv | 110 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-port scheduler.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int REG_ZERO = 0;
   localparam int REG_LAST = 31;

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_t;

   typedef enum logic {
      REQ_MD = 1'b0,
      REQ_C0 = 1'b1
   } req_t;

endpackage

// File: rtl/regfile_wb_sched_pick.sv
// Two-way round-robin picker for the secondary writers (mult/div and CP0).
module wb_rr_pick
   import regfile_pkg::*;
(
   input  logic req_md,
   input  logic req_c0,
   input  req_t last,
   input  logic inhibit,
   output logic gnt_md,
   output logic gnt_c0
);

   // On a tie the writer that did not win most recently goes first.
   always_comb begin
      gnt_md = 1'b0;
      gnt_c0 = 1'b0;
      if (!inhibit) begin
         if (req_md && req_c0) begin
            gnt_md = (last == REQ_C0);
            gnt_c0 = (last == REQ_MD);
         end else begin
            gnt_md = req_md;
            gnt_c0 = req_c0;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_sched.sv
// Shares the register file's single write port between pipeline writeback,
// mult/div completion and CP0 move-from, after a zero-fill of r1..r31.
module regfile_wb_sched #(
   parameter int DATA_W     = regfile_pkg::DATA_W,
   parameter int ADDR_W     = regfile_pkg::ADDR_W,
   parameter int STARVE_MAX = 4
) (
   input  logic              reg_clk,
   input  logic              rst,
   input  logic              pri_valid,
   input  logic [ADDR_W-1:0] pri_addr,
   input  logic [DATA_W-1:0] pri_data,
   input  logic              md_valid,
   input  logic [ADDR_W-1:0] md_addr,
   input  logic [DATA_W-1:0] md_data,
   output logic              md_ready,
   input  logic              c0_valid,
   input  logic [ADDR_W-1:0] c0_addr,
   input  logic [DATA_W-1:0] c0_data,
   output logic              c0_ready,
   output logic              reg_ena,
   output logic              reg_w,
   output logic [ADDR_W-1:0] RdC,
   output logic [DATA_W-1:0] Rd_data_in,
   output logic              busy,
   output logic              stall_req
);

   import regfile_pkg::*;

   state_t            state;
   req_t              last;
   logic [ADDR_W-1:0] clr_ptr;
   logic [3:0]        starve;
   logic [3:0]        starve_nxt;
   logic              gnt_md;
   logic              gnt_c0;
   logic              inhibit;

   // Secondaries only compete in RUN when the pipeline leaves the port free.
   assign inhibit  = rst || (state != S_RUN) || pri_valid;
   assign md_ready = gnt_md;
   assign c0_ready = gnt_c0;
   assign reg_ena  = 1'b1;
   assign busy     = (state == S_CLEAR);

   wb_rr_pick u_pick (
      .req_md  (md_valid),
      .req_c0  (c0_valid),
      .last    (last),
      .inhibit (inhibit),
      .gnt_md  (gnt_md),
      .gnt_c0  (gnt_c0)
   );

   always_comb begin
      starve_nxt = starve;
      if (gnt_md || gnt_c0)
         starve_nxt = 4'd0;
      else if ((md_valid || c0_valid) && (starve != 4'hF))
         starve_nxt = starve + 4'd1;
   end

   // Register 0 transfers are consumed but never strobe the write port.
   always_ff @(posedge reg_clk) begin
      if (rst) begin
         state      <= S_CLEAR;
         clr_ptr    <= ADDR_W'(1);
         last       <= REQ_C0;
         starve     <= 4'd0;
         stall_req  <= 1'b0;
         reg_w      <= 1'b0;
         RdC        <= '0;
         Rd_data_in <= '0;
      end else begin
         starve    <= starve_nxt;
         stall_req <= (starve_nxt >= 4'(STARVE_MAX));
         case (state)
            S_CLEAR: begin
               reg_w      <= 1'b1;
               RdC        <= clr_ptr;
               Rd_data_in <= '0;
               clr_ptr    <= clr_ptr + ADDR_W'(1);
               if (clr_ptr == ADDR_W'(REG_LAST))
                  state <= S_RUN;
            end
            default: begin
               if (pri_valid) begin
                  reg_w      <= (pri_addr != ADDR_W'(REG_ZERO));
                  RdC        <= pri_addr;
                  Rd_data_in <= pri_data;
               end else if (gnt_md) begin
                  reg_w      <= (md_addr != ADDR_W'(REG_ZERO));
                  RdC        <= md_addr;
                  Rd_data_in <= md_data;
                  last       <= REQ_MD;
               end else if (gnt_c0) begin
                  reg_w      <= (c0_addr != ADDR_W'(REG_ZERO));
                  RdC        <= c0_addr;
                  Rd_data_in <= c0_data;
                  last       <= REQ_C0;
               end else begin
                  reg_w <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule
